// File: rtl/fir_lms_ctrl.sv
// Sequencer for an LMS-adapted FIR: loads initial coefficients, gates adaptation, and watches error windows for convergence/divergence.
// Latency: start to first coefficient write 1 cycle; window evaluation acts on the cycle after the closing sample.
// Backpressure: none; samples arrive on s_valid and are consumed or dropped in the same cycle.
module fir_lms_ctrl #(
    parameter int L         = 33,
    parameter int CW        = 16,
    parameter int EW        = 36,
    parameter int INIT_COEF = 70,
    parameter int WIN_LOG2  = 8,
    parameter int CONV_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 freeze_req,
    input  logic                 s_valid,
    input  logic signed [EW-1:0] e_in,
    input  logic [23:0]          thr_lo,
    input  logic [23:0]          thr_hi,
    output logic                 coef_we,
    output logic [5:0]           coef_addr,
    output logic [CW-1:0]        coef_data,
    output logic                 adapt_en,
    output logic                 sample_en,
    output logic                 busy,
    output logic                 converged,
    output logic [2:0]           state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ADAPT  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_FREEZE = 3'd4;

    // Magnitude is taken in a width one bit wider than the error so that
    // negating the most negative value cannot overflow.
    localparam int MW = ((EW > 16) ? EW : 16) + 1;
    localparam int GW = $clog2(CONV_CNT + 1);

    localparam logic [5:0]    LAST_ADDR = 6'(L - 1);
    localparam logic [CW-1:0] INIT_C    = CW'(INIT_COEF);
    localparam logic [GW-1:0] CONV_C    = GW'(CONV_CNT);

    logic [2:0]          state_q, state_d;
    logic [5:0]          load_cnt_q;
    logic [23:0]         acc_q;
    logic [WIN_LOG2-1:0] win_cnt_q;
    logic [GW-1:0]       good_q;
    logic                conv_q;

    logic signed [MW-1:0] e_ext;
    logic [MW-1:0]        mag_full;
    logic [15:0]          mag;
    logic [23:0]          win_sum;
    logic [GW-1:0]        good_inc;
    logic                 mon_active;
    logic                 win_end;
    logic                 lo_hit;
    logic                 hi_hit;
    logic                 conv_hit;

    // Saturated magnitude of the error sample and the window bookkeeping it feeds
    always_comb begin
        e_ext    = MW'(e_in);
        mag_full = e_ext[MW-1] ? MW'(-e_ext) : MW'(e_ext);
        mag      = (|mag_full[MW-1:16]) ? 16'hFFFF : mag_full[15:0];
        win_sum  = acc_q + {8'd0, mag};
        good_inc = good_q + 1'b1;
        // start and freeze_req both pre-empt monitoring, so a window closing
        // on the same cycle as either of them is thrown away.
        mon_active = ((state_q == S_ADAPT) || (state_q == S_HOLD)) && !start && !freeze_req;
        win_end    = mon_active && s_valid && (&win_cnt_q);
        lo_hit     = (win_sum < thr_lo);
        hi_hit     = (win_sum > thr_hi);
        conv_hit   = (good_inc == CONV_C);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, priority start > freeze_req > window evaluation
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_cnt_q == LAST_ADDR) state_d = S_ADAPT;
            end
            S_ADAPT: begin
                if (start)                               state_d = S_LOAD;
                else if (freeze_req)                     state_d = S_FREEZE;
                else if (win_end && lo_hit && conv_hit)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (start)                  state_d = S_LOAD;
                else if (freeze_req)        state_d = S_FREEZE;
                else if (win_end && hi_hit) state_d = S_ADAPT;
            end
            S_FREEZE: begin
                if (start)           state_d = S_LOAD;
                else if (!freeze_req) state_d = S_ADAPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state; sample_en is the only output that looks at an input
    always_comb begin
        coef_we   = 1'b0;
        coef_addr = 6'd0;
        coef_data = '0;
        adapt_en  = 1'b0;
        sample_en = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_LOAD: begin
                coef_we   = 1'b1;
                coef_addr = load_cnt_q;
                coef_data = INIT_C;
                busy      = 1'b1;
            end
            S_ADAPT: begin
                adapt_en  = 1'b1;
                sample_en = s_valid;
                busy      = 1'b1;
            end
            S_HOLD, S_FREEZE: begin
                sample_en = s_valid;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign converged = conv_q;
    assign state     = state_q;

    // Load address counter, window accumulator, good-window count and convergence flag
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_q <= 6'd0;
            acc_q      <= 24'd0;
            win_cnt_q  <= '0;
            good_q     <= '0;
            conv_q     <= 1'b0;
        end else begin
            load_cnt_q <= ((state_q == S_LOAD) && (load_cnt_q != LAST_ADDR)) ? load_cnt_q + 6'd1 : 6'd0;
            // Converged is exactly "now sitting in HOLD".
            conv_q     <= (state_d == S_HOLD);
            if (!mon_active) begin
                acc_q     <= 24'd0;
                win_cnt_q <= '0;
                good_q    <= '0;
            end else if (s_valid) begin
                if (win_end) begin
                    acc_q     <= 24'd0;
                    win_cnt_q <= '0;
                    good_q    <= ((state_q == S_ADAPT) && lo_hit && !conv_hit) ? good_inc : '0;
                end else begin
                    acc_q     <= win_sum;
                    win_cnt_q <= win_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_lms_ctrl.sv
// Directed bench for fir_lms_ctrl: coefficient load, window-based convergence/divergence, freeze, restart and reset.
// Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
// Small window (4 samples) and two good windows keep the sequences short.
module tb_fir_lms_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               freeze_req;
    logic               s_valid;
    logic signed [35:0] e_in;
    logic [23:0]        thr_lo;
    logic [23:0]        thr_hi;
    logic               coef_we;
    logic [5:0]         coef_addr;
    logic [15:0]        coef_data;
    logic               adapt_en;
    logic               sample_en;
    logic               busy;
    logic               converged;
    logic [2:0]         state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic               sv;
        logic signed [35:0] e;
        logic [23:0]        lo;
        logic [23:0]        hi;
        logic [2:0]         st;
        logic               cv;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    fir_lms_ctrl #(
        .L(33), .CW(16), .EW(36), .INIT_COEF(70), .WIN_LOG2(2), .CONV_CNT(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .freeze_req(freeze_req),
        .s_valid(s_valid), .e_in(e_in), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .adapt_en(adapt_en), .sample_en(sample_en), .busy(busy),
        .converged(converged), .state(state)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic signed [35:0] e, input logic [23:0] lo,
                       input logic [23:0] hi, input logic [2:0] st, input logic cv);
        vec_t v;
        v.sv = sv; v.e = e; v.lo = lo; v.hi = hi; v.st = st; v.cv = cv;
        tbl.push_back(v);
    endtask

    task automatic feed(input logic signed [35:0] e, input int n);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            e_in    = e;
            cyc();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [35:0] emin;
        emin = {1'b1, 35'd0};

        // Window sequences starting in ADAPT with an empty window and zero good count
        // convergence: window 1 sum 0, idle cycle, window 2 sum 0 -> HOLD
        for (int k = 0; k < 4; k++) add(1, 0, 10, 300, 2, 0);
        add(0, 5, 10, 300, 2, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 10, 300, 2, 0);
        add(1, 0, 10, 300, 3, 1);
        // HOLD with sum equal to thr_hi stays
        for (int k = 0; k < 4; k++) add(1, 75, 10, 300, 3, 1);
        // divergence: sum 400 > 300
        for (int k = 0; k < 3; k++) add(1, 100, 10, 300, 3, 1);
        add(1, 100, 10, 300, 2, 0);
        // sum of negative errors equal to thr_lo is not good
        add(1, -3, 10, 300, 2, 0); add(1, -3, 10, 300, 2, 0);
        add(1, -2, 10, 300, 2, 0); add(1, -2, 10, 300, 2, 0);
        // good window, then a not-good one that must clear the count
        for (int k = 0; k < 4; k++) add(1, 0, 10, 300, 2, 0);
        add(1, 3, 10, 300, 2, 0); add(1, 3, 10, 300, 2, 0);
        add(1, 2, 10, 300, 2, 0); add(1, 2, 10, 300, 2, 0);
        // two good windows -> HOLD
        for (int k = 0; k < 7; k++) add(1, 0, 10, 300, 2, 0);
        add(1, 0, 10, 300, 3, 1);
        // saturated samples: window sum 262140, not above 262140
        for (int k = 0; k < 4; k++) add(1, emin, 10, 262140, 3, 1);
        // but above 262139
        for (int k = 0; k < 3; k++) add(1, emin, 10, 262139, 3, 1);
        add(1, emin, 10, 262139, 2, 0);

        reset = 1'b1; start = 1'b0; freeze_req = 1'b0; s_valid = 1'b1;
        e_in = '0; thr_lo = 24'd10; thr_hi = 24'd300;
        cyc(); cyc();
        chk("rst_state", state, 0);
        chk("rst_coef_we", coef_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_adapt_en", adapt_en, 0);
        chk("rst_converged", converged, 0);
        chk("rst_sample_en", sample_en, 0);
        reset = 1'b0;
        cyc(); cyc();
        chk("inert_state", state, 0);
        chk("inert_sample_en", sample_en, 0);
        chk("inert_coef_addr", coef_addr, 0);

        // Coefficient load, with a stray start mid-load and samples to drop
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("load_we[%0d]", i), coef_we, 1);
            chk($sformatf("load_addr[%0d]", i), coef_addr, i);
            chk($sformatf("load_data[%0d]", i), coef_data, 70);
            chk($sformatf("load_state[%0d]", i), state, 1);
            chk($sformatf("load_sample_en[%0d]", i), sample_en, 0);
            start = (i == 5);
            cyc();
        end
        start = 1'b0;
        s_valid = 1'b0;
        chk("post_load_state", state, 2);
        chk("post_load_adapt_en", adapt_en, 1);
        chk("post_load_coef_we", coef_we, 0);
        chk("post_load_busy", busy, 1);
        chk("post_load_converged", converged, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            s_valid = tbl[i].sv; e_in = tbl[i].e; thr_lo = tbl[i].lo; thr_hi = tbl[i].hi;
            #1;
            chk($sformatf("vec%0d_sample_en", i), sample_en, tbl[i].sv);
            cyc();
            chk($sformatf("vec%0d_state", i), state, tbl[i].st);
            chk($sformatf("vec%0d_converged", i), converged, tbl[i].cv);
            chk($sformatf("vec%0d_adapt_en", i), adapt_en, (tbl[i].st == 3'd2));
            chk($sformatf("vec%0d_coef_we", i), coef_we, 0);
        end

        // Freeze in ADAPT, landing on the sample that would have closed a converging window
        thr_lo = 24'd10; thr_hi = 24'd300;
        feed(0, 4);
        feed(0, 3);
        chk("pre_freeze_state", state, 2);
        freeze_req = 1'b1; s_valid = 1'b1; e_in = '0;
        #1;
        chk("freeze_edge_sample_en", sample_en, 1);
        cyc();
        chk("freeze_state", state, 4);
        chk("freeze_adapt_en", adapt_en, 0);
        chk("freeze_busy", busy, 1);
        chk("freeze_converged", converged, 0);
        #1;
        chk("freeze_sample_en_hi", sample_en, 1);
        s_valid = 1'b0;
        #1;
        chk("freeze_sample_en_lo", sample_en, 0);
        cyc();
        chk("freeze_hold_state", state, 4);
        freeze_req = 1'b0;
        cyc();
        chk("release_state", state, 2);
        chk("release_adapt_en", adapt_en, 1);
        feed(0, 4);
        chk("release_win1_state", state, 2);
        feed(0, 3);
        chk("release_7_state", state, 2);
        feed(0, 1);
        chk("release_8_state", state, 3);
        chk("release_8_converged", converged, 1);

        // Freeze in HOLD drops convergence
        freeze_req = 1'b1;
        cyc();
        chk("hold_freeze_state", state, 4);
        chk("hold_freeze_converged", converged, 0);
        freeze_req = 1'b0;
        cyc();
        chk("hold_release_state", state, 2);

        // start beats freeze_req in ADAPT, then reset in the middle of the load
        start = 1'b1; freeze_req = 1'b1;
        cyc();
        start = 1'b0; freeze_req = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_addr", coef_addr, 0);
        chk("restart_coef_we", coef_we, 1);
        for (int k = 0; k < 10; k++) cyc();
        chk("midload_addr", coef_addr, 10);
        reset = 1'b1;
        cyc();
        chk("midload_rst_state", state, 0);
        chk("midload_rst_coef_we", coef_we, 0);
        chk("midload_rst_addr", coef_addr, 0);
        chk("midload_rst_data", coef_data, 0);
        chk("midload_rst_busy", busy, 0);
        reset = 1'b0; s_valid = 1'b1;
        cyc(); cyc();
        chk("post_rst_state", state, 0);
        chk("post_rst_sample_en", sample_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
